// File: rtl/plab4_net_router_input_queue_sep_pkg.sv
// Shared plab4-net definitions: the domain encoding, plus the width and position
// of the destination field that the router input control logic also relies on.
package plab4_net_router_input_queue_sep_pkg;

  typedef enum logic {
    DOMAIN_D1 = 1'b0,
    DOMAIN_D2 = 1'b1
  } domain_e;

  // The destination router id is the most significant field of a message.
  function automatic int unsigned dest_nbits(input int unsigned num_routers);
    return $clog2(num_routers);
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned msg_nbits,
                                           input int unsigned dst_nbits);
    return msg_nbits - dst_nbits;
  endfunction

endpackage

// File: rtl/plab4_net_router_domain_queue.sv
// Single-domain FIFO. Full and empty are decoded from an occupancy count, and a
// full queue refuses an enqueue even when it is dequeuing in the same cycle.
module plab4_net_router_domain_queue #(
  parameter int unsigned p_msg_nbits   = 44,
  parameter int unsigned p_num_entries = 4,
  localparam int unsigned c_ptr_nbits  = $clog2(p_num_entries),
  localparam int unsigned c_cnt_nbits  = $clog2(p_num_entries) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [c_cnt_nbits-1:0] num_free
);

  logic [p_msg_nbits-1:0] mem_q [p_num_entries];
  logic [c_ptr_nbits-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_nbits-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_nbits-1:0] count_q, count_d;
  logic                   enq_fire;
  logic                   deq_fire;

  // Status is decoded from registered state only.
  assign enq_rdy  = (count_q != c_cnt_nbits'(p_num_entries));
  assign deq_val  = (count_q != '0);
  assign deq_msg  = mem_q[rd_ptr_q];
  assign num_free = c_cnt_nbits'(p_num_entries) - count_q;

  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + c_ptr_nbits'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + c_ptr_nbits'(1);
    if (enq_fire && !deq_fire) count_d = count_q + c_cnt_nbits'(1);
    if (!enq_fire && deq_fire) count_d = count_q - c_cnt_nbits'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_msg;
  end

endmodule

// File: rtl/plab4_net_router_input_queue_sep.sv
// Router input queue with separate FIFOs for the two domains, sharing one input
// port; each domain's head and destination feed the separable arbiter directly.
module plab4_net_router_input_queue_sep
  import plab4_net_router_input_queue_sep_pkg::*;
#(
  parameter int unsigned p_num_routers = 8,
  parameter int unsigned p_msg_nbits   = 44,
  parameter int unsigned p_num_entries = 4,
  localparam int unsigned c_dest_nbits = dest_nbits(p_num_routers),
  localparam int unsigned c_free_nbits = $clog2(p_num_entries) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [p_msg_nbits-1:0]  in_msg,
  input  logic                    in_domain,
  output logic                    out_val_d1,
  input  logic                    out_rdy_d1,
  output logic [p_msg_nbits-1:0]  out_msg_d1,
  output logic [c_dest_nbits-1:0] dest_d1,
  output logic                    out_val_d2,
  input  logic                    out_rdy_d2,
  output logic [p_msg_nbits-1:0]  out_msg_d2,
  output logic [c_dest_nbits-1:0] dest_d2,
  output logic [c_free_nbits-1:0] num_free_d1,
  output logic [c_free_nbits-1:0] num_free_d2
);

  localparam int unsigned c_dest_lsb = dest_lsb(p_msg_nbits, c_dest_nbits);

  domain_e dom;
  logic    enq_val_d1, enq_val_d2;
  logic    enq_rdy_d1, enq_rdy_d2;

  // Steer the single input to the queue named by in_domain.
  assign dom        = domain_e'(in_domain);
  assign enq_val_d1 = in_val & (dom == DOMAIN_D1);
  assign enq_val_d2 = in_val & (dom == DOMAIN_D2);
  assign in_rdy     = (dom == DOMAIN_D2) ? enq_rdy_d2 : enq_rdy_d1;

  plab4_net_router_domain_queue #(
    .p_msg_nbits   (p_msg_nbits),
    .p_num_entries (p_num_entries)
  ) u_queue_d1 (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (enq_val_d1),
    .enq_rdy  (enq_rdy_d1),
    .enq_msg  (in_msg),
    .deq_val  (out_val_d1),
    .deq_rdy  (out_rdy_d1),
    .deq_msg  (out_msg_d1),
    .num_free (num_free_d1)
  );

  plab4_net_router_domain_queue #(
    .p_msg_nbits   (p_msg_nbits),
    .p_num_entries (p_num_entries)
  ) u_queue_d2 (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (enq_val_d2),
    .enq_rdy  (enq_rdy_d2),
    .enq_msg  (in_msg),
    .deq_val  (out_val_d2),
    .deq_rdy  (out_rdy_d2),
    .deq_msg  (out_msg_d2),
    .num_free (num_free_d2)
  );

  assign dest_d1 = out_msg_d1[c_dest_lsb +: c_dest_nbits];
  assign dest_d2 = out_msg_d2[c_dest_lsb +: c_dest_nbits];

endmodule

// File: doc/plab4_net_router_input_queue_sep.md
PLAB4_NET_ROUTER_INPUT_QUEUE_SEP -- requirements
Module: plab4_net_router_input_queue_sep

Interface
REQ-001 SHALL have parameter p_num_routers, default 8: network size; c_dest_nbits = $clog2(p_num_routers).
REQ-002 SHALL have parameter p_msg_nbits, default 44: message width, dest field in msg[p_msg_nbits-1 -: c_dest_nbits].
REQ-003 SHALL have parameter p_num_entries, default 4: depth of each per-domain queue, power of two, >= 2.
REQ-004 SHALL have ports: clk  in  1  clock, single clock domain, all state on rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: in_val  in  1; in_rdy  out  1; in_msg  in  p_msg_nbits; in_domain  in  1 (0 = domain1, 1 = domain2).
REQ-007 SHALL have ports: out_val_d1  out  1; out_rdy_d1  in  1; out_msg_d1  out  p_msg_nbits; dest_d1  out  c_dest_nbits.
REQ-008 SHALL have ports: out_val_d2  out  1; out_rdy_d2  in  1; out_msg_d2  out  p_msg_nbits; dest_d2  out  c_dest_nbits.
REQ-009 SHALL have ports: num_free_d1, num_free_d2  out  $clog2(p_num_entries)+1  free entries per queue.

Function
REQ-010 SHALL hold two independent FIFOs, one per domain; no entry, pointer or counter shared between domains.
REQ-011 SHALL steer in_msg to the domain1 queue when in_domain = 0, domain2 queue when in_domain = 1.
REQ-012 SHALL drive in_rdy = not-full of the queue selected by in_domain, combinationally; in_rdy independent of in_val.
REQ-013 SHALL enqueue exactly when in_val & in_rdy on a rising edge; no other queue affected.
REQ-014 SHALL drive out_val_dX = queue X non-empty; out_msg_dX = head entry; dest_dX = dest field of head entry.
REQ-015 SHALL dequeue queue X exactly when out_val_dX & out_rdy_dX on a rising edge.
REQ-016 SHALL have enqueue-to-out_val latency of one cycle; no combinational bypass from in_msg to out_msg_dX.
REQ-017 SHALL allow simultaneous enqueue and dequeue on the same queue: count unchanged, both pointers advance.
REQ-018 SHALL refuse enqueue to a full queue even if that queue dequeues in the same cycle (no pipelined full).
REQ-019 SHALL allow dequeues from both queues plus one enqueue in the same cycle.
REQ-020 SHALL wrap read/write pointers modulo p_num_entries; full/empty derived from an occupancy count 0..p_num_entries.
REQ-021 SHALL drive num_free_dX = p_num_entries - count_X, registered-state derived (no input-to-output path).
REQ-022 SHALL keep out_msg_dX/dest_dX stable while out_val_dX = 1 and out_rdy_dX = 0.
REQ-023 SHALL hold out_msg_dX/dest_dX don't-care when out_val_dX = 0; the bench SHALL NOT check them.

Reset
REQ-024 SHALL, on reset assertion, immediately clear both counts and pointers: out_val_d1 = out_val_d2 = 0, num_free_dX = p_num_entries, in_rdy = 1.
REQ-025 SHALL discard all queued messages on reset mid-operation; storage array need not be cleared.
REQ-026 SHALL ignore in_val and out_rdy_dX while reset is high.

Structure
REQ-027 SHALL instantiate one sub-module plab4_net_router_domain_queue (single FIFO, parameters p_msg_nbits, p_num_entries) twice.
REQ-028 SHALL place c_dest_nbits derivation and the dest-field slice position in the shared plab4-net package/header used by RouterInputCtrl, so dest_dX matches its dest input.
REQ-029 SHALL connect dest_dX/out_val_dX/out_rdy_dX directly to the Arb_Sep dest_dX/in_val_dX/in_rdy_dX ports.

Verification
REQ-030 SHALL test: reset, then in_val=1, in_domain=0, msg dest=3 -> next cycle out_val_d1=1, dest_d1=3, out_val_d2=0, num_free_d1=3.
REQ-031 SHALL test: fill domain2 with 4 msgs, out_rdy_d2=0 -> in_rdy=0 when in_domain=1, in_rdy=1 when in_domain=0; domain1 still accepts.
REQ-032 SHALL test: domain2 full, out_rdy_d2=1 and enqueue attempt to domain2 same cycle -> dequeue occurs, no enqueue, num_free_d2=1.
REQ-033 SHALL test: 10 interleaved msgs alternating domains, random out_rdy stalls -> each domain emits its msgs in order, no cross-domain leakage, pointers wrap.
REQ-034 SHALL test: simultaneous enq/deq on domain1 with count=2 -> count stays 2, head advances to next msg.
REQ-035 SHALL test: reset asserted asynchronously mid-cycle with 3 msgs queued -> out_val_d1/d2 fall before next clk edge, num_free = 4.
